// File: rtl/ahb_mtx_pkg.sv
// Shared AHB matrix encodings: HTRANS/HRESP codes, address width and the
// address-phase bundle held by the input stages.
package ahb_mtx_pkg;

  localparam int AHB_AW = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef struct packed {
    logic [AHB_AW-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic              lock;
  } ahb_aphase_t;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_HOLD = 1'b1
  } in_state_e;

endpackage

// File: rtl/ahb_mtx_in_stage.sv
// AHB matrix input stage: forwards the master address phase with zero latency,
// holds it while the target port is busy. AHB_MTX_IN_STAGE_ERR_CANCEL_EN enables ERROR-driven cancel of held SEQ beats.
module ahb_mtx_in_stage
  import ahb_mtx_pkg::*;
(
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [AHB_AW-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  output logic              sel_dec,
  output logic [AHB_AW-1:0] addr_dec,
  output logic [1:0]        trans_dec,
  output logic              write_dec,
  output logic [2:0]        size_dec,
  output logic [2:0]        burst_dec,
  output logic [3:0]        prot_dec,
  output logic              lock_dec,
  output logic              req_dec,
  input  logic              active_dec,
  input  logic              readyout_dec,
  input  logic              resp_dec
);

  in_state_e   state_q, state_d;
  ahb_aphase_t hold_q, hold_d, live, dec;
  logic        dphase_q, dphase_d;
  logic        hold, valid, grant, accepted, err1, err2, cancel, err2_rdy;

  assign live = '{addr: HADDRS, trans: HTRANSS, write: HWRITES, size: HSIZES,
                  burst: HBURSTS, prot: HPROTS, lock: HMASTLOCKS};

  assign hold  = (state_q == ST_HOLD);
  assign valid = HSELS & HREADYS & HTRANSS[1];
  assign grant = active_dec & readyout_dec;
  assign err1  = dphase_q & resp_dec & ~readyout_dec;
  assign err2  = dphase_q & resp_dec & readyout_dec;

`ifdef AHB_MTX_IN_STAGE_ERR_CANCEL_EN
  // A SEQ beat behind an ERROR is dropped; the master will re-issue or abort.
  assign cancel   = hold & err1 & (hold_q.trans == HTRANS_SEQ);
  assign err2_rdy = err2;
`else
  assign cancel   = 1'b0;
  assign err2_rdy = 1'b0;
`endif

  // err1 implies readyout_dec=0, so cancel and grant never coincide.
  assign accepted = grant & (hold | valid);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    dphase_d = dphase_q;
    if (!hold) begin
      if (valid && !grant) begin
        state_d = ST_HOLD;
        hold_d  = live;
      end
    end else if (grant || cancel) begin
      state_d = ST_PASS;
    end
    if (accepted)          dphase_d = 1'b1;
    else if (readyout_dec) dphase_d = 1'b0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_PASS;
      hold_q   <= '0;
      dphase_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      dphase_q <= dphase_d;
    end
  end

  assign dec       = hold ? hold_q : live;
  assign sel_dec   = hold | HSELS;
  assign addr_dec  = dec.addr;
  assign trans_dec = dec.trans;
  assign write_dec = dec.write;
  assign size_dec  = dec.size;
  assign burst_dec = dec.burst;
  assign prot_dec  = dec.prot;
  assign lock_dec  = dec.lock;
  assign req_dec   = hold ? ~cancel : (HSELS & HTRANSS[1]);

  assign HREADYOUTS = hold ? err2_rdy : (dphase_q ? readyout_dec : 1'b1);
  assign HRESPS     = dphase_q & resp_dec;

endmodule

// File: tb/tb_ahb_mtx_in_stage.sv
// Directed bench for ahb_mtx_in_stage: a transfer-level model checked on every
// falling edge, plus hand-computed literal checks along the directed sequence.
module tb_ahb_mtx_in_stage;

`ifdef AHB_MTX_IN_STAGE_ERR_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic        HSELS = 0, HWRITES = 0, HMASTLOCKS = 0, HREADYS = 1;
  logic [31:0] HADDRS = 0;
  logic [1:0]  HTRANSS = 0;
  logic [2:0]  HSIZES = 3'b010, HBURSTS = 3'b001;
  logic [3:0]  HPROTS = 4'b0011;
  logic        active_dec = 0, readyout_dec = 1, resp_dec = 0;
  logic        HREADYOUTS, HRESPS, sel_dec, write_dec, lock_dec, req_dec;
  logic [31:0] addr_dec;
  logic [1:0]  trans_dec;
  logic [2:0]  size_dec, burst_dec;
  logic [3:0]  prot_dec;

  ahb_mtx_in_stage dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .sel_dec(sel_dec),
    .addr_dec(addr_dec), .trans_dec(trans_dec), .write_dec(write_dec),
    .size_dec(size_dec), .burst_dec(burst_dec), .prot_dec(prot_dec),
    .lock_dec(lock_dec), .req_dec(req_dec), .active_dec(active_dec),
    .readyout_dec(readyout_dec), .resp_dec(resp_dec)
  );

  always #5 HCLK = ~HCLK;

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transfer-level model: a pending (waiting) address phase and whether a
  // data phase is outstanding toward the slave.
  bit          m_pend = 0, m_dph = 0;
  logic [31:0] m_addr = 0;
  logic [1:0]  m_trans = 0;
  logic        m_write = 0, m_lock = 0;
  logic [2:0]  m_size = 0, m_burst = 0;
  logic [3:0]  m_prot = 0;

  always @(posedge HCLK or negedge HRESETn) begin : model
    bit won, took, first_err;
    if (!HRESETn) begin
      m_pend <= 0; m_dph <= 0; m_addr <= 0; m_trans <= 0; m_write <= 0;
      m_lock <= 0; m_size <= 0; m_burst <= 0; m_prot <= 0;
    end else begin
      won       = active_dec && readyout_dec;
      first_err = m_dph && resp_dec && !readyout_dec;
      if (m_pend) begin
        took = won;
        if (won || (CANCEL_EN && first_err && m_trans == 2'b11)) m_pend <= 0;
      end else begin
        took = HSELS && HREADYS && HTRANSS[1] && won;
        if (HSELS && HREADYS && HTRANSS[1] && !won) begin
          m_pend <= 1; m_addr <= HADDRS; m_trans <= HTRANSS; m_write <= HWRITES;
          m_lock <= HMASTLOCKS; m_size <= HSIZES; m_burst <= HBURSTS; m_prot <= HPROTS;
        end
      end
      if (took)              m_dph <= 1;
      else if (readyout_dec) m_dph <= 0;
    end
  end

  always @(negedge HCLK) begin : compare
    bit cancel_now, err2_now;
    cancel_now = CANCEL_EN && m_pend && m_dph && resp_dec && !readyout_dec && m_trans == 2'b11;
    err2_now   = CANCEL_EN && m_dph && resp_dec && readyout_dec;
    chk("cyc sel_dec",   sel_dec,   m_pend ? 1 : HSELS);
    chk("cyc addr_dec",  addr_dec,  m_pend ? m_addr : HADDRS);
    chk("cyc trans_dec", trans_dec, m_pend ? m_trans : HTRANSS);
    chk("cyc write_dec", write_dec, m_pend ? m_write : HWRITES);
    chk("cyc size_dec",  size_dec,  m_pend ? m_size : HSIZES);
    chk("cyc burst_dec", burst_dec, m_pend ? m_burst : HBURSTS);
    chk("cyc prot_dec",  prot_dec,  m_pend ? m_prot : HPROTS);
    chk("cyc lock_dec",  lock_dec,  m_pend ? m_lock : HMASTLOCKS);
    chk("cyc req_dec",   req_dec,   m_pend ? !cancel_now : (HSELS && HTRANSS[1]));
    chk("cyc HREADYOUTS", HREADYOUTS, m_pend ? err2_now : (m_dph ? readyout_dec : 1));
    chk("cyc HRESPS",    HRESPS,    m_dph ? resp_dec : 0);
  end

  task automatic drv(input bit sel, input logic [31:0] a, input logic [1:0] t,
                     input bit w, input bit lk, input bit hr,
                     input bit act, input bit rdy, input bit rsp);
    HSELS = sel; HADDRS = a; HTRANSS = t; HWRITES = w; HMASTLOCKS = lk;
    HREADYS = hr; active_dec = act; readyout_dec = rdy; resp_dec = rsp;
    #1;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    // reset: stage idle-ready, request follows live inputs
    drv(0, 32'h0, 2'b00, 0, 0, 1, 0, 1, 1);
    chk("rst HREADYOUTS", HREADYOUTS, 1);
    chk("rst HRESPS", HRESPS, 0);
    chk("rst req idle", req_dec, 0);
    drv(1, 32'h1234, 2'b10, 0, 0, 1, 0, 1, 0);
    chk("rst req live", req_dec, 1);
    chk("rst addr live", addr_dec, 32'h1234);
    tick(); tick();
    HRESETn = 1'b1;
    drv(0, 32'h0, 2'b00, 0, 0, 1, 0, 1, 0);
    tick();

    // granted pass-through
    drv(1, 32'h2000_0000, 2'b10, 1, 0, 1, 1, 1, 0);
    chk("pass addr", addr_dec, 32'h2000_0000);
    chk("pass HREADYOUTS", HREADYOUTS, 1);
    chk("pass req", req_dec, 1);
    chk("pass write", write_dec, 1);
    tick();
    drv(0, 32'h0, 2'b00, 0, 0, 1, 1, 1, 0);
    chk("pass dphase ready", HREADYOUTS, 1);
    chk("pass idle req", req_dec, 0);
    tick();

    // ungranted locked NONSEQ is held; a stray HREADYS=1 in HOLD is ignored
    drv(1, 32'h4000_0010, 2'b10, 0, 1, 1, 0, 1, 0);
    chk("hold entry ready", HREADYOUTS, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(1, 32'hDEAD_0000 + i, 2'b10, 0, 0, (i == 2), 0, 1, 0);
      chk("hold HREADYOUTS", HREADYOUTS, 0);
      chk("hold addr", addr_dec, 32'h4000_0010);
      chk("hold lock", lock_dec, 1);
      chk("hold sel", sel_dec, 1);
      chk("hold req", req_dec, 1);
      tick();
    end
    drv(1, 32'hDEAD_0009, 2'b10, 0, 0, 0, 1, 1, 0);
    chk("hold grant addr", addr_dec, 32'h4000_0010);
    chk("hold grant ready", HREADYOUTS, 0);
    tick();
    drv(0, 32'h0, 2'b00, 0, 0, 1, 0, 1, 0);
    chk("release addr live", addr_dec, 32'h0);
    chk("release ready", HREADYOUTS, 1);
    chk("release req", req_dec, 0);
    tick();

    // wait-stated data phase
    drv(1, 32'h3000_0004, 2'b10, 0, 0, 1, 1, 1, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drv(0, 32'h0, 2'b00, 0, 0, 0, 1, 0, 0);
      chk("wait HREADYOUTS", HREADYOUTS, 0);
      tick();
    end
    drv(0, 32'h0, 2'b00, 0, 0, 0, 1, 1, 0);
    chk("wait done", HREADYOUTS, 1);
    tick();
    drv(0, 32'h0, 2'b00, 0, 0, 1, 1, 0, 0);
    chk("dphase cleared", HREADYOUTS, 1);
    tick();

    // two-cycle ERROR passes through
    drv(1, 32'h3000_0008, 2'b10, 0, 0, 1, 1, 1, 0);
    tick();
    drv(0, 32'h0, 2'b00, 0, 0, 0, 1, 0, 1);
    chk("err1 resp", HRESPS, 1);
    chk("err1 ready", HREADYOUTS, 0);
    tick();
    drv(0, 32'h0, 2'b00, 0, 0, 0, 1, 1, 1);
    chk("err2 resp", HRESPS, 1);
    chk("err2 ready", HREADYOUTS, 1);
    tick();
    drv(0, 32'h0, 2'b00, 0, 0, 1, 1, 1, 1);
    chk("resp masked", HRESPS, 0);
    tick();

    // BUSY never captured
    drv(1, 32'h5000_0000, 2'b01, 0, 0, 1, 0, 1, 0);
    chk("busy ready", HREADYOUTS, 1);
    chk("busy req", req_dec, 0);
    chk("busy trans", trans_dec, 2'b01);
    tick();
    drv(0, 32'h6000_0000, 2'b00, 0, 0, 1, 0, 1, 0);
    chk("busy no hold addr", addr_dec, 32'h6000_0000);
    chk("busy no hold sel", sel_dec, 0);
    tick();

    // held SEQ while the previous beat takes an ERROR
    drv(1, 32'h7000_0000, 2'b10, 0, 0, 1, 1, 1, 0);
    tick();
    drv(1, 32'h7000_0004, 2'b11, 0, 0, 1, 0, 0, 0);
    chk("seq capture ready", HREADYOUTS, 0);
    tick();
    drv(1, 32'h7000_0008, 2'b11, 0, 0, 0, 0, 0, 1);
    chk("e1 req", req_dec, CANCEL_EN ? 0 : 1);
    chk("e1 resp", HRESPS, 1);
    chk("e1 ready", HREADYOUTS, 0);
    chk("e1 addr", addr_dec, 32'h7000_0004);
    tick();
    drv(0, 32'h0, 2'b00, 0, 0, 0, 0, 1, 1);
    chk("e2 resp", HRESPS, 1);
    chk("e2 req", req_dec, CANCEL_EN ? 0 : 1);
    chk("e2 ready", HREADYOUTS, CANCEL_EN ? 1 : 0);
    tick();
    drv(0, 32'h0, 2'b00, 0, 0, 0, 1, 1, 0);
    chk("e3 req", req_dec, CANCEL_EN ? 0 : 1);
    chk("e3 addr", addr_dec, CANCEL_EN ? 32'h0 : 32'h7000_0004);
    tick();
    drv(0, 32'h0, 2'b00, 0, 0, 1, 0, 1, 0);
    chk("e4 ready", HREADYOUTS, 1);
    tick();

    // reset while holding drops the held transfer at once
    drv(1, 32'h8000_0000, 2'b10, 0, 0, 1, 0, 1, 0);
    tick();
    drv(0, 32'h0, 2'b00, 0, 0, 0, 0, 1, 0);
    chk("pre-rst hold", HREADYOUTS, 0);
    HRESETn = 1'b0;
    #1;
    chk("async rst ready", HREADYOUTS, 1);
    chk("async rst req", req_dec, 0);
    chk("async rst sel", sel_dec, 0);
    tick();
    HRESETn = 1'b1;
    drv(0, 32'h0, 2'b00, 0, 0, 1, 1, 1, 0);
    chk("post-rst req", req_dec, 0);
    chk("post-rst ready", HREADYOUTS, 1);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_mtx_in_stage.md
AHB_MTX_IN_STAGE -- requirements
Module: ahb_mtx_in_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the following ports (clock and reset first).
- HCLK  in  1  AHB system clock, all state on rising edge
- HRESETn  in  1  asynchronous active-low reset
- HSELS  in  1  master-side slave select
- HADDRS  in  32  master address
- HTRANSS  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITES  in  1  write flag
- HSIZES  in  3  transfer size
- HBURSTS  in  3  burst type
- HPROTS  in  4  protection
- HMASTLOCKS  in  1  locked transfer
- HREADYS  in  1  shared bus HREADY
- HREADYOUTS  out  1  ready back to master
- HRESPS  out  1  response back to master: OKAY=0, ERROR=1
- sel_dec  out  1  select toward decoder/arbiters
- addr_dec  out  32  address toward decoder/arbiters
- trans_dec  out  2  transfer type toward decoder/arbiters
- write_dec  out  1  write flag toward decoder/arbiters
- size_dec  out  3  size toward decoder/arbiters
- burst_dec  out  3  burst toward decoder/arbiters
- prot_dec  out  4  protection toward decoder/arbiters
- lock_dec  out  1  lock toward decoder/arbiters
- req_dec  out  1  request, feeds an arbiter req_portN
- active_dec  in  1  output arbiter currently selects this port
- readyout_dec  in  1  downstream HREADYOUT of the selected slave
- resp_dec  in  1  downstream HRESP of the selected slave

Function
REQ-002 A valid transfer SHALL be defined as HSELS & HREADYS & HTRANSS[1].
REQ-003 The block SHALL implement two states: PASS (no held transfer) and HOLD (address phase registered).
REQ-004 In PASS the *_dec outputs SHALL equal the live master inputs, with zero latency.
REQ-005 In HOLD the *_dec outputs SHALL equal the registered copy, and sel_dec SHALL be 1.
REQ-006 A transfer SHALL be defined as accepted when active_dec & readyout_dec.
REQ-007 PASS->HOLD SHALL occur when a valid transfer is not accepted in the same cycle; all address-phase fields SHALL be captured.
REQ-008 HOLD->PASS SHALL occur on the first cycle in which the held transfer is accepted.
REQ-009 req_dec SHALL be 1 in HOLD, and in PASS while sel_dec & trans_dec[1]; otherwise req_dec SHALL be 0.
REQ-010 A data_phase flag SHALL be set on acceptance.
REQ-011 data_phase SHALL clear on readyout_dec=1 when no new acceptance occurs in the same cycle.
REQ-012 HREADYOUTS SHALL be 0 in HOLD.
REQ-013 Outside HOLD, HREADYOUTS SHALL equal readyout_dec while data_phase=1, and 1 otherwise.
REQ-014 HRESPS SHALL equal resp_dec while data_phase=1, else OKAY.
REQ-015 A two-cycle ERROR response (cycle 1: resp=1, ready=0; cycle 2: resp=1, ready=1) SHALL pass through unaltered.
REQ-016 BUSY or IDLE on HTRANSS SHALL never be captured and SHALL never set data_phase.
REQ-017 A held locked transfer SHALL keep lock_dec=1 until accepted.
REQ-018 A simultaneous capture and release condition SHALL be impossible, because HREADYS=0 while HOLD drives HREADYOUTS=0; if HREADYS=1 is nonetheless seen in HOLD, the new transfer SHALL be ignored and the held one kept.

Reset
REQ-019 On HRESETn=0 the block SHALL enter PASS with data_phase=0 and all held registers=0.
REQ-020 While in reset, HREADYOUTS SHALL be 1, HRESPS=OKAY, and req_dec SHALL follow the live inputs.
REQ-021 Reset asserted mid-HOLD SHALL discard the held transfer with no request issued.

Configuration
REQ-022 With AHB_MTX_IN_STAGE_ERR_CANCEL_EN defined: in the first ERROR cycle, a held SEQ transfer SHALL be discarded (HOLD->PASS, req_dec=0).
REQ-023 With AHB_MTX_IN_STAGE_ERR_CANCEL_EN defined: in the second ERROR cycle, HREADYOUTS SHALL be 1 and a held NONSEQ transfer SHALL be kept.
REQ-024 Without AHB_MTX_IN_STAGE_ERR_CANCEL_EN: held transfers SHALL proceed regardless of ERROR.

Structure
REQ-025 HTRANS and HRESP encodings and the address width constant SHALL reside in shared package ahb_mtx_pkg.
REQ-026 The block SHALL be a single flat module with no sub-module.

Verification
REQ-027 Granted pass-through: active_dec=1, readyout_dec=1, NONSEQ write to 0x2000_0000 -> addr_dec=0x2000_0000 in the same cycle, HREADYOUTS=1, state stays PASS.
REQ-028 Ungranted: NONSEQ to 0x4000_0010 with active_dec=0 for 3 cycles -> HOLD, HREADYOUTS=0 for 3 cycles, addr_dec=0x4000_0010; active_dec=1 -> PASS next cycle.
REQ-029 Wait-stated data phase: accepted transfer, readyout_dec=0 for 2 cycles -> HREADYOUTS=0 for 2 cycles, then 1; data_phase clears.
REQ-030 ERROR with ERR_CANCEL_EN, SEQ held -> req_dec=0 in ERROR cycle 1; HRESPS=1 on both cycles; no held transfer issued.
REQ-031 Reset mid-HOLD: HRESETn=0 asynchronously -> HREADYOUTS=1 and req_dec=0 immediately (live HTRANSS=IDLE).
REQ-032 BUSY inside a burst with active_dec=0 -> no capture; HREADYOUTS=1; state stays PASS.
